// File: rtl/vga_timing_delay_line_if.sv
// VGA timing + pixel bundle between a timing/pixel source and the delay line.
// Signal names keep the *_in / *_out pairing seen from the delay line.
interface vga_timing_delay_line_if #(
   parameter int HW = 11,
   parameter int VW = 11,
   parameter int DW = 12
);
   logic [HW-1:0] hcount_in;
   logic [VW-1:0] vcount_in;
   logic          hsync_in;
   logic          vsync_in;
   logic          hblnk_in;
   logic          vblnk_in;
   logic [DW-1:0] rgb_in;

   logic [HW-1:0] hcount_out;
   logic [VW-1:0] vcount_out;
   logic          hsync_out;
   logic          vsync_out;
   logic          hblnk_out;
   logic          vblnk_out;
   logic [DW-1:0] rgb_out;
   logic          valid_out;

   modport master (
      output hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in,
      input  hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out,
             valid_out
   );

   modport slave (
      input  hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in,
      output hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out,
             valid_out
   );
endinterface

// File: rtl/vga_timing_delay_line.sv
// DEPTH-cycle delay of VGA timing plus one pixel bus; pixel data is masked and
// valid_out held low until the first full frame after reset reaches the output.
module vga_timing_delay_line #(
   parameter int DEPTH = 2,
   parameter int HW    = 11,
   parameter int VW    = 11,
   parameter int DW    = 12
) (
   input  logic                   clk,
   input  logic                   rst_n,
   vga_timing_delay_line_if.slave vga
);
   generate
      if (DEPTH < 1 || DEPTH > 16) begin : g_bad_depth
         $error("vga_timing_delay_line: DEPTH must be in 1..16");
      end
   endgenerate

   localparam int CW = (DEPTH < 1) ? 1 : $clog2(DEPTH + 1);

   typedef struct packed {
      logic [HW-1:0] hc;
      logic [VW-1:0] vc;
      logic          hs;
      logic          vs;
      logic          hb;
      logic          vb;
      logic [DW-1:0] rgb;
   } stage_t;

   typedef enum logic [1:0] {FILL, ALIGN, RUN} state_t;

   stage_t        w_in;
   stage_t        w_last;
   stage_t        r_pipe [DEPTH];

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_fill_cnt;
   logic [CW-1:0] w_fill_cnt_nxt;
   logic          r_valid;
   logic          w_valid_nxt;
   logic          w_frame_start;

   assign w_in = '{hc: vga.hcount_in, vc: vga.vcount_in, hs: vga.hsync_in, vs: vga.vsync_in,
                   hb: vga.hblnk_in, vb: vga.vblnk_in, rgb: vga.rgb_in};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) r_pipe[k] <= '0;
      end else begin
         r_pipe[0] <= w_in;
         for (int k = 1; k < DEPTH; k++) r_pipe[k] <= r_pipe[k-1];
      end
   end

   assign w_last = r_pipe[DEPTH-1];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= FILL;
         r_fill_cnt <= '0;
         r_valid    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_fill_cnt <= w_fill_cnt_nxt;
         r_valid    <= w_valid_nxt;
      end
   end

   // Frame start is judged on the output side so alignment follows the delayed stream.
   always_comb begin
      w_state_nxt    = r_state;
      w_fill_cnt_nxt = r_fill_cnt;
      w_frame_start  = (w_last.hc == '0) && (w_last.vc == '0);
      case (r_state)
         FILL: begin
            if (r_fill_cnt != CW'(DEPTH)) w_fill_cnt_nxt = r_fill_cnt + 1'b1;
            if (r_fill_cnt == CW'(DEPTH - 1)) w_state_nxt = ALIGN;
         end
         ALIGN: begin
            if (w_frame_start) w_state_nxt = RUN;
         end
         RUN: begin
            w_state_nxt = RUN;
         end
         default: begin
            w_state_nxt = FILL;
         end
      endcase
      w_valid_nxt = (w_state_nxt == RUN);
   end

   assign vga.hcount_out = w_last.hc;
   assign vga.vcount_out = w_last.vc;
   assign vga.hsync_out  = w_last.hs;
   assign vga.vsync_out  = w_last.vs;
   assign vga.hblnk_out  = w_last.hb;
   assign vga.vblnk_out  = w_last.vb;
   assign vga.rgb_out    = r_valid ? w_last.rgb : '0;
   assign vga.valid_out  = r_valid;
endmodule

// File: tb/tb_vga_timing_delay_line.sv
// Directed bench: table of hand-computed vectors on DEPTH=2, then frame sequences
// on DEPTH=5/1/16 covering alignment, ignored stale frame start and mid-frame reset.
module tb_vga_timing_delay_line;
   localparam int HFR = 16;
   localparam int VFR = 4;

   typedef struct packed {
      logic [10:0] h;
      logic [10:0] v;
      logic [3:0]  s;   // {hsync, vsync, hblnk, vblnk}
      logic [11:0] rgb;
   } vin_t;

   typedef struct packed {
      vin_t d;
      logic valid;
   } vout_t;

   typedef struct {
      logic  rst;
      vin_t  in;
      vout_t exp;
   } vec_t;

   logic  clk;
   logic  rst_arr [4];
   vin_t  in_arr  [4];
   vout_t out_arr [4];
   int    n_chk;
   int    n_err;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   genvar g;
   generate
      for (g = 0; g < 4; g++) begin : g_dut
         localparam int D = (g == 0) ? 2 : (g == 1) ? 5 : (g == 2) ? 1 : 16;
         vga_timing_delay_line_if #(.HW(11), .VW(11), .DW(12)) u_if ();
         vga_timing_delay_line #(.DEPTH(D), .HW(11), .VW(11), .DW(12)) u_dut (
            .clk   (clk),
            .rst_n (rst_arr[g]),
            .vga   (u_if)
         );
         assign u_if.hcount_in = in_arr[g].h;
         assign u_if.vcount_in = in_arr[g].v;
         assign u_if.hsync_in  = in_arr[g].s[3];
         assign u_if.vsync_in  = in_arr[g].s[2];
         assign u_if.hblnk_in  = in_arr[g].s[1];
         assign u_if.vblnk_in  = in_arr[g].s[0];
         assign u_if.rgb_in    = in_arr[g].rgb;
         assign out_arr[g] = {u_if.hcount_out, u_if.vcount_out, u_if.hsync_out, u_if.vsync_out,
                              u_if.hblnk_out, u_if.vblnk_out, u_if.rgb_out, u_if.valid_out};
      end
   endgenerate

   function automatic vin_t mk(input int h, input int v, input logic [3:0] s, input logic [11:0] rgb);
      vin_t r;
      r.h   = 11'(h);
      r.v   = 11'(v);
      r.s   = s;
      r.rgb = rgb;
      return r;
   endfunction

   function automatic vout_t mo(input vin_t d, input logic valid);
      vout_t r;
      r.d     = d;
      r.valid = valid;
      return r;
   endfunction

   task automatic chk(input string name, input vout_t got, input vout_t exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got h=%0d v=%0d s=%b rgb=%h valid=%b, expected h=%0d v=%0d s=%b rgb=%h valid=%b",
                  name, got.d.h, got.d.v, got.d.s, got.d.rgb, got.valid,
                  exp.d.h, exp.d.v, exp.d.s, exp.d.rgb, exp.valid);
      end
   endtask

   task automatic tick(input int sel, input logic rst, input vin_t x);
      rst_arr[sel] = rst;
      in_arr[sel]  = x;
      @(posedge clk);
      #1;
   endtask

   task automatic reset_tick(input int sel, input string name, input vin_t x);
      tick(sel, 1'b0, x);
      chk(name, out_arr[sel], mo(mk(0, 0, 4'h0, 12'h0), 1'b0));
   endtask

   // Released cycles n=1..ncyc with a running frame counter starting at (h0,v0);
   // valid_out is expected from cycle vstart onward (hand-computed per call).
   task automatic run_seq(input int sel, input int d, input string name,
                          input int h0, input int v0, input int ncyc, input int vstart);
      vin_t  hist [$];
      vin_t  x;
      vout_t e;
      int    h;
      int    v;
      h = h0;
      v = v0;
      for (int n = 1; n <= ncyc; n++) begin
         x = mk(h, v, 4'($urandom), 12'($urandom));
         tick(sel, 1'b1, x);
         hist.push_back(x);
         e = mo(mk(0, 0, 4'h0, 12'h0), 1'b0);
         if (hist.size() >= d) e.d = hist[hist.size() - d];
         e.valid = (n >= vstart);
         if (!e.valid) e.d.rgb = '0;
         chk($sformatf("%s n=%0d", name, n), out_arr[sel], e);
         h++;
         if (h == HFR) begin
            h = 0;
            v = (v == VFR - 1) ? 0 : v + 1;
         end
      end
   endtask

   vec_t tbl [15];
   vin_t ones, zero, prev, x;

   initial begin
      n_chk = 0;
      n_err = 0;
      ones  = mk(2047, 2047, 4'hF, 12'hFFF);
      zero  = mk(0, 0, 4'h0, 12'h0);
      for (int i = 0; i < 4; i++) begin
         rst_arr[i] = 1'b0;
         in_arr[i]  = zero;
      end

      // DEPTH=2: out after edge n shows the input sampled at edge n-1.
      tbl[0]  = '{1'b0, ones, mo(zero, 1'b0)};
      tbl[1]  = '{1'b0, ones, mo(zero, 1'b0)};
      tbl[2]  = '{1'b1, ones, mo(zero, 1'b0)};
      tbl[3]  = '{1'b1, mk(5, 7, 4'b0101, 12'h123),    mo(mk(2047, 2047, 4'hF, 12'h0), 1'b0)};
      tbl[4]  = '{1'b1, mk(0, 0, 4'b1010, 12'hABC),    mo(mk(5, 7, 4'b0101, 12'h0), 1'b0)};
      tbl[5]  = '{1'b1, mk(1, 0, 4'b0000, 12'h456),    mo(mk(0, 0, 4'b1010, 12'h0), 1'b0)};
      tbl[6]  = '{1'b1, mk(2, 0, 4'b1111, 12'h789),    mo(mk(1, 0, 4'b0000, 12'h456), 1'b1)};
      tbl[7]  = '{1'b1, mk(3, 0, 4'b0011, 12'hFFF),    mo(mk(2, 0, 4'b1111, 12'h789), 1'b1)};
      tbl[8]  = '{1'b1, mk(799, 524, 4'b1100, 12'h001), mo(mk(3, 0, 4'b0011, 12'hFFF), 1'b1)};
      tbl[9]  = '{1'b1, mk(0, 0, 4'b0000, 12'h000),    mo(mk(799, 524, 4'b1100, 12'h001), 1'b1)};
      tbl[10] = '{1'b0, ones, mo(zero, 1'b0)};
      tbl[11] = '{1'b1, mk(4, 4, 4'b0110, 12'h5A5),    mo(zero, 1'b0)};
      tbl[12] = '{1'b1, mk(0, 0, 4'b1001, 12'hAAA),    mo(mk(4, 4, 4'b0110, 12'h0), 1'b0)};
      tbl[13] = '{1'b1, mk(1, 0, 4'b0000, 12'hBBB),    mo(mk(0, 0, 4'b1001, 12'h0), 1'b0)};
      tbl[14] = '{1'b1, mk(2, 0, 4'b0000, 12'hCCC),    mo(mk(1, 0, 4'b0000, 12'hBBB), 1'b1)};

      #2;
      for (int i = 0; i < 15; i++) begin
         tick(0, tbl[i].rst, tbl[i].in);
         chk($sformatf("tbl%0d", i), out_arr[0], tbl[i].exp);
      end

      // DEPTH=2 ramp in RUN: every field delayed exactly two samples.
      prev = tbl[14].in;
      for (int h = 0; h < 800; h++) begin
         x = mk(h, 10, 4'($urandom), 12'($urandom));
         tick(0, 1'b1, x);
         chk($sformatf("d2_ramp h=%0d", h), out_arr[0], mo(prev, 1'b1));
         prev = x;
      end

      // DEPTH=5, release mid-frame at (10,3): next (0,0) is input #7 -> valid from cycle 12.
      reset_tick(1, "d5_mid_rst0", ones);
      reset_tick(1, "d5_mid_rst1", ones);
      run_seq(1, 5, "d5_mid", 10, 3, 30, 12);

      // DEPTH=5, frame start present while in reset and zeros in FILL are ignored;
      // following frame start is input #64 -> valid from cycle 69.
      reset_tick(1, "d5_skip_rst0", ones);
      reset_tick(1, "d5_skip_rst1", mk(0, 0, 4'hF, 12'hFFF));
      run_seq(1, 5, "d5_skip", 1, 0, 80, 69);

      // DEPTH=5, one-cycle reset while in RUN, restart at (5,2): (0,0) is input #28 -> 33.
      reset_tick(1, "d5_rerun_rst", ones);
      run_seq(1, 5, "d5_rerun", 5, 2, 40, 33);

      // DEPTH=1: one FILL cycle, then immediate alignment.
      reset_tick(2, "d1_rst0", ones);
      reset_tick(2, "d1_rst1", ones);
      run_seq(2, 1, "d1_a", 0, 0, 12, 2);
      reset_tick(2, "d1_rst2", ones);
      run_seq(2, 1, "d1_b", 3, 3, 20, 15);

      // DEPTH=16: sixteen FILL cycles, latency 16.
      reset_tick(3, "d16_rst0", ones);
      reset_tick(3, "d16_rst1", ones);
      run_seq(3, 16, "d16", 0, 0, 40, 17);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
